reg_dump_reader: RTL

Sequential reader that walks the CPU register file through one of its combinational read ports and streams every register out as a valid/ready beat tagged with its address. It sits beside the register file in the single-cycle datapath and serves the debug/trace path: the bench or a debug host pulses `start` and receives an ordered snapshot of r0..r31 without stalling the write port.

---
 rtl/reg_dump_reader.sv | 81 ++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Walks the register file read port and streams r0..rNREGS-1 as addressed valid/ready beats.
// One beat per cycle; a stalled beat holds with ra frozen. Skips r0 when REG_DUMP_SKIP_ZERO_EN is defined.
module reg_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam logic [AW-1:0] FIRST = AW'(1);
`else
  localparam logic [AW-1:0] FIRST = '0;
`endif
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0] state;
  logic       capture;

  // A new beat is loaded on entry from LOAD and on every non-final handshake.
  assign capture = (state == S_LOAD) ||
                   ((state == S_STREAM) && m_valid && m_ready && !m_last);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ra      <= FIRST;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_addr  <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        m_data  <= rd;
        m_addr  <= ra;
        m_last  <= (ra == LAST);
        ra      <= ra + 1'b1;
        m_valid <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (m_valid && m_ready && m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
            ra      <= FIRST;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
